// File: rtl/fetch_controller_pkg.sv
// Shared widths, constants and state encoding for the instruction fetch controller.
package fetch_controller_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h3000_0000;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_e;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_controller_fifo.sv
// Show-ahead FIFO holding {pc, instr} entries between fetch and decode.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && !empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, issues single-outstanding imem
// requests, buffers returned instructions and handles redirects.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        dec_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  fetch_state_e         state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 req_q, req_d;

  logic                 fifo_flush;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [ENTRY_W-1:0]   fifo_head;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;

  logic                 xfer_done;
  logic                 pend_next;
  logic [OCC_W-1:0]     occ_next;
  logic [ADDR_W-1:0]    redirect_tgt;

  assign xfer_done    = req_q && imem_ack;
  assign redirect_tgt = word_align(redirect_pc);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    req_d      = req_q;
    fifo_flush = OFF;
    fifo_push  = OFF;
    fifo_pop   = OFF;
    pend_next  = OFF;
    occ_next   = '0;
    case (state_q)
      S_BOOT: begin
        if (redirect_valid) pc_d = redirect_tgt;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (redirect_valid) begin
          fifo_flush = ON;
          pc_d       = redirect_tgt;
          if (!req_q || imem_ack) begin
            req_d  = ON;
            addr_d = redirect_tgt;
          end else begin
            // A request in flight cannot be withdrawn; wait it out.
            state_d = S_FLUSH;
          end
        end else begin
          fifo_pop  = !fifo_empty && dec_ready;
          fifo_push = xfer_done;
          if (xfer_done) pc_d = pc_q + 32'd4;
          pend_next = req_q && !imem_ack;
          occ_next  = OCC_W'(fifo_count) + OCC_W'(fifo_push) - OCC_W'(fifo_pop);
          if (pend_next) begin
            req_d = ON;
          end else if (occ_next < OCC_W'(QDEPTH)) begin
            req_d  = ON;
            addr_d = pc_d;
          end else begin
            req_d = OFF;
          end
        end
      end
      S_FLUSH: begin
        fifo_flush = redirect_valid;
        if (redirect_valid) pc_d = redirect_tgt;
        if (xfer_done) begin
          req_d = OFF;
        end else if (!req_q) begin
          req_d   = ON;
          addr_d  = pc_d;
          state_d = S_RUN;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= OFF;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  // Pending requests are counted against capacity, so a push never meets a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(fifo_push && fifo_full && !fifo_pop));
      if (req_q && !imem_ack) assert (req_d && (addr_d == addr_q));
    end
  end

  fetch_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({addr_q, imem_rdata}),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_valid  = !fifo_empty;
  assign if_pc     = fifo_head[ENTRY_W-1:INSTR_W];
  assign if_instr  = fifo_head[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_controller.sv
// Directed and randomized bench for fetch_controller with a transaction-level reference model.
module tb_fetch_controller;

  localparam logic [31:0] RPC = 32'h3000_0000;
  localparam int          QD  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int checks = 0;
  int errors = 0;

  // Reference state: expected delivered stream and next expected fetch address.
  logic [63:0] exp_q[$];
  logic [31:0] exp_next;
  bit          stale;
  bit          prev_hold;
  logic [31:0] prev_addr;
  int          completions = 0;
  int          wcnt = 0;
  int          lat = 0;
  int          cur_lat = 0;
  bit          rand_lat = 1'b0;
  int          c0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_controller #(
    .RESET_PC (RPC),
    .QDEPTH   (QD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_ready      (dec_ready),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: called just after a negedge with inputs set; plays the
  // memory, checks outputs against the model, then advances to the next negedge.
  task automatic cyc();
    logic [63:0] head;
    if (rst) begin
      imem_ack  = 1'b0;
      wcnt      = 0;
      exp_q.delete();
      exp_next  = RPC;
      stale     = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("req_held", {31'b0, imem_req}, 32'd1);
        chk("addr_held", imem_addr, prev_addr);
      end
      if (imem_req) begin
        if (wcnt == 0) cur_lat = rand_lat ? int'($urandom_range(0, 3)) : lat;
        imem_ack = (wcnt >= cur_lat);
      end else begin
        imem_ack = rand_lat ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (imem_req && !imem_ack) wcnt++;
      else wcnt = 0;

      chk("if_valid", {31'b0, if_valid}, {31'b0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        chk("if_pc", if_pc, head[63:32]);
        chk("if_instr", if_instr, head[31:0]);
      end
      chk("occupancy", {31'b0, exp_q.size() <= QD}, 32'd1);

      if (if_valid && dec_ready && !redirect_valid && exp_q.size() != 0) void'(exp_q.pop_front());
      if (imem_req && imem_ack) begin
        completions++;
        if (!stale) chk("fetch_addr", imem_addr, exp_next);
        if (!stale && !redirect_valid) begin
          exp_q.push_back({exp_next, mem_word(exp_next)});
          exp_next = exp_next + 32'd4;
        end
        stale = 1'b0;
      end
      if (redirect_valid) begin
        exp_q.delete();
        exp_next = {redirect_pc[31:2], 2'b00};
        if (imem_req && !imem_ack) stale = 1'b1;
      end
      prev_hold = imem_req && !imem_ack;
      prev_addr = imem_addr;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic redir(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    cyc();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_ready      = 1'b1;
    imem_ack       = 1'b0;
    @(negedge clk);
    repeat (3) cyc();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_instr", if_instr, 32'd0);

    // Reset release with zero-wait memory
    rst = 1'b0;
    cyc();
    chk("boot_idle", {31'b0, imem_req}, 32'd0);
    cyc();
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RPC);
    chk("first_novalid", {31'b0, if_valid}, 32'd0);
    cyc();
    chk("first_valid", {31'b0, if_valid}, 32'd1);
    chk("first_pc", if_pc, RPC);
    chk("first_instr", if_instr, mem_word(RPC));
    chk("stream_addr1", imem_addr, RPC + 32'd4);
    cyc();
    chk("second_pc", if_pc, RPC + 32'd4);
    chk("stream_addr2", imem_addr, RPC + 32'd8);
    repeat (4) cyc();

    // 3-cycle memory: one completion every three cycles
    lat = 2;
    c0  = completions;
    repeat (12) cyc();
    chk("lat3_completions", completions - c0, 32'd4);

    // Back-pressure from reset
    rst = 1'b1;
    repeat (2) cyc();
    rst       = 1'b0;
    lat       = 0;
    dec_ready = 1'b0;
    c0        = completions;
    repeat (12) cyc();
    chk("bp_completions", completions - c0, 32'd2);
    chk("bp_req", {31'b0, imem_req}, 32'd0);
    chk("bp_valid", {31'b0, if_valid}, 32'd1);
    chk("bp_head", if_pc, RPC);
    dec_ready = 1'b1;
    cyc();
    chk("drain_pc0", if_pc, RPC + 32'd4);
    chk("resume_req", {31'b0, imem_req}, 32'd1);
    chk("resume_addr", imem_addr, RPC + 32'd8);
    cyc();
    chk("drain_pc1", if_pc, RPC + 32'd8);

    // Redirect with nothing pending
    dec_ready = 1'b0;
    repeat (5) cyc();
    chk("full_idle", {31'b0, imem_req}, 32'd0);
    redir(32'h3000_0102);
    chk("redir_flush", {31'b0, if_valid}, 32'd0);
    chk("redir_req", {31'b0, imem_req}, 32'd1);
    chk("redir_addr", imem_addr, 32'h3000_0100);
    cyc();
    chk("redir_valid", {31'b0, if_valid}, 32'd1);
    chk("redir_pc", if_pc, 32'h3000_0100);

    // Redirect while a 4-cycle request is pending
    repeat (4) cyc();
    chk("full_idle2", {31'b0, imem_req}, 32'd0);
    lat = 3;
    redir(32'h3000_0010);
    chk("pend_req", {31'b0, imem_req}, 32'd1);
    chk("pend_addr", imem_addr, 32'h3000_0010);
    redir(32'h3000_0200);
    for (int i = 0; i < 3; i++) begin
      chk("flush_hold_req", {31'b0, imem_req}, 32'd1);
      chk("flush_hold_addr", imem_addr, 32'h3000_0010);
      chk("flush_novalid", {31'b0, if_valid}, 32'd0);
      if (i < 2) cyc();
    end
    cyc();
    chk("flush_idle", {31'b0, imem_req}, 32'd0);
    chk("flush_idle_valid", {31'b0, if_valid}, 32'd0);
    cyc();
    chk("flush_reissue", {31'b0, imem_req}, 32'd1);
    chk("flush_reissue_addr", imem_addr, 32'h3000_0200);

    // Redirect coincident with ack and pop, then two redirects while flushing
    lat       = 0;
    dec_ready = 1'b1;
    repeat (4) cyc();
    chk("pre_valid", {31'b0, if_valid}, 32'd1);
    chk("pre_req", {31'b0, imem_req}, 32'd1);
    redir(32'h3000_0400);
    chk("coinc_flush", {31'b0, if_valid}, 32'd0);
    chk("coinc_req", {31'b0, imem_req}, 32'd1);
    chk("coinc_addr", imem_addr, 32'h3000_0400);
    lat = 2;
    redir(32'h3000_0500);
    chk("dbl_hold_addr", imem_addr, 32'h3000_0400);
    redir(32'h3000_0600);
    chk("dbl_hold_req", {31'b0, imem_req}, 32'd1);
    chk("dbl_novalid", {31'b0, if_valid}, 32'd0);
    cyc();
    chk("dbl_idle", {31'b0, imem_req}, 32'd0);
    cyc();
    chk("dbl_req", {31'b0, imem_req}, 32'd1);
    chk("dbl_addr", imem_addr, 32'h3000_0600);
    lat = 0;
    cyc();
    chk("dbl_valid", {31'b0, if_valid}, 32'd1);
    chk("dbl_pc", if_pc, 32'h3000_0600);

    // Reset mid-transaction, then redirect during boot
    lat = 3;
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    chk("midrst_req", {31'b0, imem_req}, 32'd0);
    chk("midrst_addr", imem_addr, RPC);
    chk("midrst_valid", {31'b0, if_valid}, 32'd0);
    rst = 1'b0;
    redir(32'h7000_0006);
    chk("boot_redir_idle", {31'b0, imem_req}, 32'd0);
    cyc();
    chk("boot_redir_req", {31'b0, imem_req}, 32'd1);
    chk("boot_redir_addr", imem_addr, 32'h7000_0004);

    // Randomized traffic against the model
    rand_lat = 1'b1;
    c0       = completions;
    for (int i = 0; i < 600; i++) begin
      dec_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = $urandom;
      cyc();
    end
    redirect_valid = 1'b0;
    chk("random_progress", {31'b0, (completions - c0) > 60}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
